mat_loader: RTL and testbench
=============================

# mat_loader

Upstream loader for the `memA`/`memB` operand memories of the systolic matrix unit. It accepts one signed element per handshake from a byte stream and assembles full DIM-wide rows. Each completed A row is written into `memA` via `WrEn`/`Arow`/`Ain`. Each completed B row is shifted into `memB` via `en`/`Bin`. It then signals completion so the compute sequencer can start streaming.

## Interface
- `BITS_AB`, default 8: element width (signed two's complement).
- `DIM`, default 8: matrix dimension. Must be ≥2.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begin a load. Sampled only in IDLE.
- `in_valid` in, 1: `in_data` is valid.
- `in_ready` out, 1: loader accepts an element this cycle.
- `in_data` in, BITS_AB: signed element.
- `a_wren` out, 1: connects to `memA.WrEn`. One-cycle pulse per A row.
- `a_row` out, $clog2(DIM): connects to `memA.Arow`.
- `a_in` out, DIM × BITS_AB (unpacked `[DIM-1:0]`): connects to `memA.Ain`.
- `b_en` out, 1: connects to `memB.en`. One-cycle pulse per B row.
- `b_in` out, DIM × BITS_AB (unpacked `[DIM-1:0]`): connects to `memB.Bin`.
- `busy` out, 1: high in any state except IDLE.
- `done` out, 1: one-cycle pulse after the last B row.

## Operation
- **Stream order:** DIM·DIM A elements, row-major (row 0 first, column 0 first). Then DIM·DIM B elements, row-major in memB feed order (B row DIM-1 first, down to row 0). The loader does not reorder.
- **Row buffer:** `rowbuf[DIM]`. The element accepted at column counter `col` goes into `rowbuf[col]`. `a_in` and `b_in` are both driven from `rowbuf`, and are qualified by `a_wren` / `b_en`.
- **Counters:**
  - `col`: 0..DIM-1, cleared after each row.
  - `row`: 0..DIM-1, cleared at the A→B transition and in IDLE.
- **FSM states:**
  - IDLE: when `start`=1, go to LOAD_A with `row`=`col`=0.
  - LOAD_A: `in_ready`=1. On accept, `col`++. An accept with `col`==DIM-1 goes to WRITE_A.
  - WRITE_A: one cycle. `a_wren`=1, `a_row`=`row`, `in_ready`=0. If `row`==DIM-1, go to LOAD_B with `row`=0. Otherwise `row`++ and go to LOAD_A.
  - LOAD_B: same as LOAD_A. A final-column accept goes to WRITE_B.
  - WRITE_B: one cycle. `b_en`=1, `in_ready`=0. If `row`==DIM-1, go to DONE. Otherwise `row`++ and go to LOAD_B.
  - DONE: one cycle. `done`=1. Then go to IDLE.
- **Ignored inputs:** `start` is ignored outside IDLE. `in_valid` is ignored whenever `in_ready`=0; there is no accept in IDLE, WRITE_x or DONE.
- **Elements:** passed through bit-exact. No arithmetic or sign extension.
- **Output timing:** all outputs are registers or pure state decodes. There is no combinational path from `in_valid`/`in_data`/`start` to any output.
- **`a_row`:** holds `row` in all states except IDLE, where it reads 0.
- **`rowbuf`:** holds its contents between rows. It is cleared only by reset.

## Timing
- **Reset values:** on `rst`=1 at a clock edge, the next state is IDLE and every output is 0: `in_ready`, `a_wren`, `a_row`, `a_in[*]`, `b_en`, `b_in[*]`, `busy`, `done`. `rowbuf` and all counters are cleared.
- **Reset mid-load:** `rst` asserted in any state aborts the load. No further `a_wren`/`b_en` pulses occur. Rows already written to memA are not undone. The next `start` begins again at A row 0.
- **Start:** `start` high at edge t puts the loader in LOAD_A, so `busy`=1 and `in_ready`=1 in cycle t+1.
- **Row write:** the last element of a row accepted at edge t gives WRITE_x during cycle t+1. The write pulse is high for exactly that cycle, with `a_in`/`b_in` stable and holding the full row.
- **Throughput:** with `in_valid` held high, each row takes DIM+1 cycles. A full load takes 2·DIM·(DIM+1) cycles from the first LOAD_A cycle to the last WRITE_B, plus one DONE cycle. For DIM=8 that is 144 + 1.
- **B feed:** `b_en` pulses are never adjacent, so memB shifts exactly once per row.
- **Bubbles:** an `in_valid` bubble stalls `col` with no other effect.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0. Assert `start`=1 with `rst`=1 → remains IDLE.
- **Nominal load, DIM=8, continuous `in_valid`:** A[i][j]=8i+j, B stream element k = −k.
  - 8 `a_wren` pulses, 9 cycles apart, with `a_row`=0..7 and `a_in[j]`=8i+j.
  - 8 `b_en` pulses with `b_in[j]`=−(8r+j).
  - `done` exactly 1 cycle after the last `b_en`.
  - `busy` high for 145 cycles.
- **Random `in_valid` gaps (~50%) on the same data:** identical pulse contents and order. `in_ready`=0 in every WRITE and DONE cycle. No element is dropped or duplicated.
- **Illegal stimulus:** `start` pulsed mid-LOAD_B and `in_valid`=1 while IDLE → no state change and no accept. Total accepted elements equal exactly 128.
- **Reset mid-operation:** `rst` after A row 3 is written and B row 2 is partially received → outputs go to 0 and no `b_en` follows. A new `start` produces `a_row`=0 first.
- **Extremes:** rows of −128 / 127 / 0 / −1 → `a_in`/`b_in` match bit-exact, with no sign corruption.

Source files
------------

// File: rtl/mat_loader.sv
`default_nettype none
// ============================================================================
// Module   : mat_loader
// Brief    : Streams signed elements into DIM-wide rows and writes them into
//            the memA / memB operand memories of the systolic matrix unit.
// Revision : 1.0 - initial release
// ============================================================================
module mat_loader #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_AB-1:0] in_data,
    output logic                      a_wren,
    output logic [$clog2(DIM)-1:0]    a_row,
    output logic signed [BITS_AB-1:0] a_in [DIM-1:0],
    output logic                      b_en,
    output logic signed [BITS_AB-1:0] b_in [DIM-1:0],
    output logic                      busy,
    output logic                      done
);

    localparam int                 c_CNT_W = $clog2(DIM);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIM - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD_A  = 3'd1;
    localparam logic [2:0] c_WRITE_A = 3'd2;
    localparam logic [2:0] c_LOAD_B  = 3'd3;
    localparam logic [2:0] c_WRITE_B = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [c_CNT_W-1:0]        r_col;
    logic [c_CNT_W-1:0]        r_row;
    logic signed [BITS_AB-1:0] r_rowbuf [DIM-1:0];
    logic                      w_accept;

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            for (int i = 0; i < DIM; i++) begin
                r_rowbuf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rowbuf[r_col] <= in_data;
                r_col           <= (r_col == c_LAST) ? '0 : r_col + c_ONE;
            end
            // Row counter wraps on the last row, which also resets it for B.
            case (r_state)
                c_IDLE: begin
                    r_col <= '0;
                    r_row <= '0;
                end
                c_WRITE_A, c_WRITE_B: r_row <= (r_row == c_LAST) ? '0 : r_row + c_ONE;
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of the state register; no input reaches them.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        a_wren      = 1'b0;
        b_en        = 1'b0;
        done        = 1'b0;
        busy        = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_LOAD_A;
            end
            c_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && (r_col == c_LAST)) w_state_nxt = c_WRITE_A;
            end
            c_WRITE_A: begin
                a_wren      = 1'b1;
                w_state_nxt = (r_row == c_LAST) ? c_LOAD_B : c_LOAD_A;
            end
            c_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && (r_col == c_LAST)) w_state_nxt = c_WRITE_B;
            end
            c_WRITE_B: begin
                b_en        = 1'b1;
                w_state_nxt = (r_row == c_LAST) ? c_DONE : c_LOAD_B;
            end
            c_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign a_row = busy ? r_row : '0;
    assign a_in  = r_rowbuf;
    assign b_in  = r_rowbuf;

endmodule
`default_nettype wire

// File: tb/tb_mat_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_loader
// Brief    : Directed self-checking bench for mat_loader (DIM=8, 8-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_loader;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              a_wren;
    logic [2:0]        a_row;
    logic signed [7:0] a_in [7:0];
    logic              b_en;
    logic signed [7:0] b_in [7:0];
    logic              busy;
    logic              done;

    mat_loader #(.BITS_AB(8), .DIM(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .a_wren   (a_wren),
        .a_row    (a_row),
        .a_in     (a_in),
        .b_en     (b_en),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observation log, filled at the falling edge.
    int          q_arow[$];
    logic [63:0] q_arows[$];
    logic [63:0] q_brows[$];
    int          q_acyc[$];
    int          q_bcyc[$];
    int          done_cnt, done_cyc, busy_cnt, acc_cnt, wr_rdy_err, b_adj_err;
    int          first_busy_cyc, first_busy_rdy, start_cyc;
    bit          prev_b, prev_busy;

    task automatic clear_log();
        q_arow.delete(); q_arows.delete(); q_brows.delete();
        q_acyc.delete(); q_bcyc.delete();
        done_cnt = 0; done_cyc = 0; busy_cnt = 0; acc_cnt = 0;
        wr_rdy_err = 0; b_adj_err = 0;
        first_busy_cyc = -1; first_busy_rdy = 0;
    endtask

    always @(negedge clk) begin
        logic [63:0] pa, pb;
        for (int j = 0; j < 8; j++) begin
            pa[j*8 +: 8] = a_in[j];
            pb[j*8 +: 8] = b_in[j];
        end
        if (a_wren) begin
            q_arow.push_back(int'(a_row));
            q_arows.push_back(pa);
            q_acyc.push_back(cyc);
        end
        if (b_en) begin
            q_brows.push_back(pb);
            q_bcyc.push_back(cyc);
            if (prev_b) b_adj_err++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (busy && !prev_busy && first_busy_cyc < 0) begin
            first_busy_cyc = cyc;
            first_busy_rdy = int'(in_ready);
        end
        if (in_valid && in_ready) acc_cnt++;
        if ((a_wren || b_en || done) && in_ready) wr_rdy_err++;
        prev_b    = b_en;
        prev_busy = busy;
    end

    // kind 0: A[i][j]=8i+j, B element k = -k; kind 1: cycling extremes.
    function automatic logic [7:0] elem(input int kind, input int k);
        logic [7:0] vals [4];
        vals[0] = 8'h80; vals[1] = 8'h7f; vals[2] = 8'h00; vals[3] = 8'hff;
        if (kind == 0) return (k < 64) ? 8'(k) : 8'(-(k - 64));
        return vals[(k + k / 8) % 4];
    endfunction

    function automatic logic [63:0] exp_row(input int kind, input int base);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[j*8 +: 8] = elem(kind, base + j);
        return r;
    endfunction

    logic [7:0] stream [128];

    task automatic fill_stream(input int kind);
        for (int k = 0; k < 128; k++) stream[k] = elem(kind, k);
    endtask

    task automatic send_stream(input int n, input int gap);
        int idx = 0;
        int budget = 0;
        while (idx < n) begin
            in_valid = (gap == 0) || ($urandom_range(99) >= gap);
            in_data  = stream[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            budget++;
            if (budget > 3000) begin
                check("stream_timeout", 64'(idx), 64'(n));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int w = 0;
        while (done_cnt == 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string nm);
        logic [63:0] pa, pb;
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            pa[j*8 +: 8] = a_in[j];
            pb[j*8 +: 8] = b_in[j];
        end
        check({nm, ":in_ready"}, 64'(in_ready), 64'd0);
        check({nm, ":a_wren"},   64'(a_wren),   64'd0);
        check({nm, ":a_row"},    64'(a_row),    64'd0);
        check({nm, ":a_in"},     pa,            64'd0);
        check({nm, ":b_en"},     64'(b_en),     64'd0);
        check({nm, ":b_in"},     pb,            64'd0);
        check({nm, ":busy"},     64'(busy),     64'd0);
        check({nm, ":done"},     64'(done),     64'd0);
    endtask

    task automatic verify(input string nm, input int kind, input bit cont);
        check({nm, ":a_pulses"},  64'(q_arow.size()),  64'd8);
        check({nm, ":b_pulses"},  64'(q_brows.size()), 64'd8);
        check({nm, ":done_cnt"},  64'(done_cnt),       64'd1);
        check({nm, ":accepted"},  64'(acc_cnt),        64'd128);
        check({nm, ":ready_wr"},  64'(wr_rdy_err),     64'd0);
        check({nm, ":b_adjacent"}, 64'(b_adj_err),     64'd0);
        for (int i = 0; i < 8 && i < q_arow.size(); i++) begin
            check($sformatf("%s:a_row%0d", nm, i), 64'(q_arow[i]), 64'(i));
            check($sformatf("%s:a_in%0d", nm, i), q_arows[i], exp_row(kind, 8 * i));
        end
        for (int r = 0; r < 8 && r < q_brows.size(); r++)
            check($sformatf("%s:b_in%0d", nm, r), q_brows[r], exp_row(kind, 64 + 8 * r));
        if (cont) begin
            check({nm, ":first_busy"}, 64'(first_busy_cyc), 64'(start_cyc));
            check({nm, ":first_rdy"},  64'(first_busy_rdy), 64'd1);
            check({nm, ":busy_cycles"}, 64'(busy_cnt), 64'd145);
            for (int i = 1; i < q_acyc.size(); i++)
                check($sformatf("%s:a_gap%0d", nm, i), 64'(q_acyc[i] - q_acyc[i-1]), 64'd9);
            if (q_bcyc.size() > 0)
                check({nm, ":done_lat"}, 64'(done_cyc - q_bcyc[q_bcyc.size()-1]), 64'd1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        clear_log();

        // Reset with random inputs toggling.
        repeat (2) begin
            start    = 1'($urandom_range(1));
            in_valid = 1'($urandom_range(1));
            in_data  = 8'($urandom_range(255));
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0;
        check_idle("reset");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("start_in_reset:busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Nominal continuous load.
        fill_stream(0);
        clear_log();
        do_start();
        send_stream(128, 0);
        wait_done();
        verify("nominal", 0, 1'b1);

        // Roughly half the cycles carry a bubble.
        clear_log();
        do_start();
        send_stream(128, 50);
        wait_done();
        verify("gaps", 0, 1'b0);

        // in_valid while idle, then a stray start pulse in the middle of LOAD_B.
        clear_log();
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_valid:busy_cycles", 64'(busy_cnt), 64'd0);
        check("idle_valid:accepted",    64'(acc_cnt),  64'd0);
        do_start();
        fork
            send_stream(128, 0);
            begin : g_start_poke
                int w = 0;
                while (q_brows.size() < 1 && w < 2000) begin
                    @(posedge clk);
                    w++;
                end
                #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        wait_done();
        verify("illegal", 0, 1'b1);

        // Abort partway through B row 2, then restart cleanly.
        clear_log();
        do_start();
        send_stream(84, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("midreset");
        clear_log();
        repeat (20) @(posedge clk);
        #1;
        check("midreset:no_b_en", 64'(q_brows.size()), 64'd0);
        check("midreset:no_done", 64'(done_cnt),       64'd0);
        do_start();
        send_stream(128, 0);
        wait_done();
        verify("restart", 0, 1'b1);

        // Extreme values -128 / 127 / 0 / -1.
        fill_stream(1);
        clear_log();
        do_start();
        send_stream(128, 0);
        wait_done();
        verify("extremes", 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
